// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants, FSM encoding and BCD step helper for the 7-segment controller
package seg7_pkg;

  localparam logic [1:0] ADDR_DATA_L = 2'd0;
  localparam logic [1:0] ADDR_DATA_H = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_FMASK  = 2'd3;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_DEC  = 1;
  localparam int CTRL_LZB  = 2;
  localparam int CTRL_BUSY = 7;

  localparam int DIG_MAX = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_LOAD = 2'd2
  } conv_state_e;

  // One double-dabble iteration on {bcd[19:0], bin[15:0]}: add 3 to each BCD nibble >= 5, then shift left.
  function automatic logic [35:0] dabble_step(input logic [35:0] s);
    logic [35:0] t;
    t = s;
    for (int i = 0; i < 5; i++) begin
      if (t[16 + 4*i +: 4] >= 4'd5) begin
        t[16 + 4*i +: 4] = t[16 + 4*i +: 4] + 4'd3;
      end
    end
    return {t[34:0], 1'b0};
  endfunction

endpackage

// File: rtl/seg7_disp_ctrl_if.sv
// rtl/seg7_disp_ctrl_if.sv - CPU register bus for the 7-segment controller
interface seg7_disp_ctrl_if;
  logic [1:0] ADDR;
  logic [7:0] DIN;
  logic       WE;
  logic       RE;
  logic [7:0] DOUT;

  modport master (output ADDR, DIN, WE, RE, input DOUT);
  modport slave  (input ADDR, DIN, WE, RE, output DOUT);
endinterface

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - 16-bit sequential double-dabble converter with start/abort/done
module bin2bcd_seq
  import seg7_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [15:0] bin_i,
  output logic [19:0] bcd_o,
  output logic        busy_o,
  output logic        done_o
);

  conv_state_e state_q;
  logic [35:0] shift_q;
  logic [3:0]  cnt_q;
  logic        busy_q;
  logic        done_q;

  // Conversion FSM: a new start always wins and restarts from scratch, so only the newest value completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (start_i) begin
      state_q <= ST_CONV;
      shift_q <= {20'b0, bin_i};
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else if (abort_i) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_CONV: begin
          shift_q <= dabble_step(shift_q);
          cnt_q   <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_q <= ST_LOAD;
            done_q  <= 1'b1;
          end
        end
        ST_LOAD: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bcd_o  = shift_q[35:16];
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: rtl/seg7_disp_ctrl.sv
// rtl/seg7_disp_ctrl.sv - register file, hex/decimal digit update and blanking for the 7-segment scanner
module seg7_disp_ctrl
  import seg7_pkg::*;
#(
  parameter int DIG_N = 8,
  parameter int W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  seg7_disp_ctrl_if.slave  bus,
  output logic [31:0]      DIGITS,
  output logic [7:0]       BLANK,
  output logic             BUSY
);

  logic [7:0]   data_l_q;
  logic [7:0]   data_h_q;
  logic [W-1:0] val_q;
  logic [2:0]   ctrl_q;
  logic [7:0]   fmask_q;
  logic [31:0]  digits_q;
  logic [7:0]   blank_q;
  logic [7:0]   dout_q;

  logic         wr_data_h;
  logic         wr_ctrl;
  logic         new_dec;
  logic         update;
  logic         conv_start;
  logic         hex_load;
  logic [W-1:0] commit_val;
  logic [19:0]  conv_bcd;
  logic         conv_busy;
  logic         conv_done;
  logic [7:0]   blank_d;
  logic [7:0]   rd_d;
  int           msd;

  // Decode writes into update requests; a DEC toggle re-renders the last committed value.
  always_comb begin
    wr_data_h  = bus.WE && (bus.ADDR == ADDR_DATA_H);
    wr_ctrl    = bus.WE && (bus.ADDR == ADDR_CTRL);
    new_dec    = wr_ctrl ? bus.DIN[CTRL_DEC] : ctrl_q[CTRL_DEC];
    update     = wr_data_h || (wr_ctrl && (bus.DIN[CTRL_DEC] != ctrl_q[CTRL_DEC]));
    commit_val = wr_data_h ? {bus.DIN, data_l_q} : val_q;
    conv_start = update && new_dec;
    hex_load   = update && !new_dec;
  end

  bin2bcd_seq u_bcd (
    .clk     (clk),
    .rst     (rst),
    .start_i (conv_start),
    .abort_i (hex_load),
    .bin_i   (commit_val),
    .bcd_o   (conv_bcd),
    .busy_o  (conv_busy),
    .done_o  (conv_done)
  );

  // Blank mask from the displayed digits: leading zeros above the top nonzero digit, never digit 0.
  always_comb begin
    msd = 0;
    for (int i = 0; i < DIG_MAX; i++) begin
      if (digits_q[4*i +: 4] != 4'd0) msd = i;
    end
    for (int i = 0; i < DIG_MAX; i++) begin
      blank_d[i] = !ctrl_q[CTRL_EN] || fmask_q[i] || (i >= DIG_N) ||
                   (ctrl_q[CTRL_LZB] && (i > msd) && (i != 0));
    end
  end

  // Read mux; CTRL reports the live conversion status in its top bit.
  always_comb begin
    rd_d = 8'h00;
    case (bus.ADDR)
      ADDR_DATA_L: rd_d = data_l_q;
      ADDR_DATA_H: rd_d = data_h_q;
      ADDR_CTRL: begin
        rd_d[2:0]       = ctrl_q;
        rd_d[CTRL_BUSY] = conv_busy;
      end
      default:     rd_d = fmask_q;
    endcase
  end

  // Register file and display registers; a conversion result is dropped if a newer update lands with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_l_q <= '0;
      data_h_q <= '0;
      val_q    <= '0;
      ctrl_q   <= '0;
      fmask_q  <= '0;
      digits_q <= '0;
      blank_q  <= 8'hFF;
      dout_q   <= '0;
    end else begin
      if (bus.WE) begin
        case (bus.ADDR)
          ADDR_DATA_L: data_l_q <= bus.DIN;
          ADDR_DATA_H: begin
            data_h_q <= bus.DIN;
            val_q    <= commit_val;
          end
          ADDR_CTRL:   ctrl_q  <= bus.DIN[2:0];
          default:     fmask_q <= bus.DIN;
        endcase
      end
      if (hex_load) begin
        digits_q <= {{(32-W){1'b0}}, commit_val};
      end else if (conv_done && !update) begin
        digits_q <= {12'b0, conv_bcd};
      end
      blank_q <= blank_d;
      if (bus.RE) dout_q <= rd_d;
    end
  end

  assign DIGITS   = digits_q;
  assign BLANK    = blank_q;
  assign BUSY     = conv_busy;
  assign bus.DOUT = dout_q;

endmodule

// File: tb/tb_seg7_disp_ctrl.sv
// tb/tb_seg7_disp_ctrl.sv - randomized self-checking bench against a behavioural display model
module tb_seg7_disp_ctrl;
  import seg7_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seg7_disp_ctrl_if bus8 ();
  seg7_disp_ctrl_if bus4 ();

  logic [31:0] digits8, digits4;
  logic [7:0]  blank8, blank4;
  logic        busy8, busy4;

  seg7_disp_ctrl #(.DIG_N(8), .W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus8.slave),
    .DIGITS(digits8), .BLANK(blank8), .BUSY(busy8)
  );

  seg7_disp_ctrl #(.DIG_N(4), .W(16)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4.slave),
    .DIGITS(digits4), .BLANK(blank4), .BUSY(busy4)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference state: what the display should show, and how many edges until a decimal result lands.
  logic [31:0] m_digits;
  logic [7:0]  m_blank8, m_blank4, m_dout, m_fmask, m_dl, m_dh;
  logic [2:0]  m_ctrl;
  logic [15:0] m_val, m_pval;
  logic        m_busy;
  int          m_pend;

  function automatic logic [31:0] dec_digits(input int v);
    logic [31:0] r;
    int p;
    r = 0;
    p = 1;
    for (int i = 0; i < 5; i++) begin
      r = r | (32'((v / p) % 10) << (4*i));
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [7:0] blank_of(input logic [31:0] d, input logic [2:0] c,
                                          input logic [7:0] fm, input int ndig);
    int msd;
    logic [7:0] b;
    msd = 0;
    for (int i = 0; i < 8; i++) if (((d >> (4*i)) & 32'hF) != 0) msd = i;
    for (int i = 0; i < 8; i++)
      b[i] = !c[0] || fm[i] || (i >= ndig) || (c[2] && (i > msd) && (i != 0));
    return b;
  endfunction

  task automatic model_reset();
    m_digits = 0; m_blank8 = 8'hFF; m_blank4 = 8'hFF; m_dout = 0;
    m_fmask = 0; m_dl = 0; m_dh = 0; m_ctrl = 0; m_val = 0; m_pval = 0;
    m_busy = 0; m_pend = 0;
  endtask

  task automatic step(input logic r, input logic [1:0] a, input logic [7:0] d,
                      input logic w, input logic rd);
    logic upd;
    logic [7:0] nb8, nb4;
    rst = r;
    bus8.ADDR = a; bus8.DIN = d; bus8.WE = w; bus8.RE = rd;
    bus4.ADDR = a; bus4.DIN = d; bus4.WE = w; bus4.RE = rd;
    @(posedge clk);
    #1;
    if (r) begin
      model_reset();
    end else begin
      nb8 = blank_of(m_digits, m_ctrl, m_fmask, 8);
      nb4 = blank_of(m_digits, m_ctrl, m_fmask, 4);
      if (rd) begin
        case (a)
          2'd0: m_dout = m_dl;
          2'd1: m_dout = m_dh;
          2'd2: m_dout = {m_busy, 4'b0, m_ctrl};
          default: m_dout = m_fmask;
        endcase
      end
      upd = 1'b0;
      if (w) begin
        case (a)
          2'd0: m_dl = d;
          2'd1: begin m_dh = d; m_val = {d, m_dl}; upd = 1'b1; end
          2'd2: begin upd = (d[1] != m_ctrl[1]); m_ctrl = d[2:0]; end
          default: m_fmask = d;
        endcase
      end
      if (upd) begin
        if (m_ctrl[1]) begin
          m_pend = 17;
          m_pval = m_val;
        end else begin
          m_pend = 0;
          m_digits = {16'b0, m_val};
        end
      end else if (m_pend > 0) begin
        m_pend--;
        if (m_pend == 0) m_digits = dec_digits(int'(m_pval));
      end
      m_busy = (m_pend > 0);
      m_blank8 = nb8;
      m_blank4 = nb4;
    end
    check("digits8", digits8, m_digits);
    check("digits4", digits4, m_digits);
    check("blank8", blank8, m_blank8);
    check("blank4", blank4, m_blank4);
    check("busy8", busy8, m_busy);
    check("busy4", busy4, m_busy);
    check("dout8", bus8.DOUT, m_dout);
    check("dout4", bus4.DOUT, m_dout);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    step(1'b0, a, d, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    bus8.ADDR = 0; bus8.DIN = 0; bus8.WE = 0; bus8.RE = 0;
    bus4.ADDR = 0; bus4.DIN = 0; bus4.WE = 0; bus4.RE = 0;
    model_reset();
    step(1'b1, 2'd0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 2'd0, 8'h00, 1'b0, 1'b0);
    idle(5);
    check("rst_digits", digits8, 32'h0);
    check("rst_blank", blank8, 8'hFF);
    check("rst_busy", busy8, 1'b0);
    check("rst_dout", bus8.DOUT, 8'h00);

    // Hex display with and without leading-zero blanking.
    wr(ADDR_CTRL, 8'h01);
    wr(ADDR_DATA_L, 8'h34);
    wr(ADDR_DATA_H, 8'h12);
    check("hex1234", digits8, 32'h0000_1234);
    idle(1);
    check("hex_blank", blank8, 8'h00);
    wr(ADDR_CTRL, 8'h05);
    idle(1);
    check("hex_lzb", blank8, 8'hF0);

    // Switch to decimal, then time a full 65535 conversion.
    wr(ADDR_CTRL, 8'h07);
    idle(20);
    check("dec4660", digits8, 32'h0000_4660);
    wr(ADDR_DATA_L, 8'hFF);
    wr(ADDR_DATA_H, 8'hFF);
    check("busy_start", busy8, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      if (k == 5) step(1'b0, ADDR_CTRL, 8'h00, 1'b0, 1'b1);
      else idle(1);
      if (k == 5) check("rd_ctrl_busy", bus8.DOUT, 8'h87);
    end
    check("busy_last", busy8, 1'b1);
    check("held_old", digits8, 32'h0000_4660);
    idle(1);
    check("dec65535", digits8, 32'h0006_5535);
    check("busy_done", busy8, 1'b0);
    idle(1);
    check("blank65535", blank8, 8'hE0);
    check("blank65535_n4", blank4, 8'hF0);

    wr(ADDR_DATA_L, 8'h00);
    wr(ADDR_DATA_H, 8'h00);
    idle(18);
    check("dec0", digits8, 32'h0);
    check("blank0", blank8, 8'hFE);

    // Restart: 1234 is superseded on conversion cycle 8 by 9999.
    wr(ADDR_DATA_L, 8'hD2);
    wr(ADDR_DATA_H, 8'h04);
    idle(7);
    wr(ADDR_DATA_L, 8'h0F);
    wr(ADDR_DATA_H, 8'h27);
    for (int k = 0; k < 17; k++) begin
      idle(1);
      check("no1234", (digits8 == 32'h1234), 1'b0);
    end
    check("dec9999", digits8, 32'h0000_9999);

    // Force-blank mask and enable.
    wr(ADDR_FMASK, 8'h02);
    wr(ADDR_CTRL, 8'h01);
    idle(2);
    check("fmask_n4", blank4, 8'hF2);
    check("fmask_n8", blank8, 8'h02);
    wr(ADDR_CTRL, 8'h00);
    idle(1);
    check("disable", blank8, 8'hFF);

    // Reset in the middle of a conversion, then a clean conversion.
    wr(ADDR_CTRL, 8'h03);
    idle(9);
    step(1'b1, 2'd0, 8'h00, 1'b0, 1'b0);
    check("rst_mid_digits", digits8, 32'h0);
    check("rst_mid_blank", blank8, 8'hFF);
    check("rst_mid_busy", busy8, 1'b0);
    wr(ADDR_CTRL, 8'h07);
    wr(ADDR_DATA_L, 8'h39);
    wr(ADDR_DATA_H, 8'h30);
    idle(17);
    check("dec12345", digits8, 32'h0001_2345);

    // Random register traffic with occasional quiet stretches and resets.
    for (int i = 0; i < 3000; i++) begin
      logic r, w, rd;
      logic [1:0] a;
      logic [7:0] d;
      r  = ($urandom_range(0, 999) == 0);
      a  = 2'($urandom_range(0, 3));
      d  = 8'($urandom);
      w  = ($urandom_range(0, 5) == 0) && ((i % 200) >= 40);
      rd = ($urandom_range(0, 2) == 0);
      step(r, a, d, w, rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg7_disp_ctrl.md
Name: seg7_disp_ctrl

Overview:
- I/O-mapped peripheral for the AVR-like core that owns the 7-segment scan datapath.
- CPU writes a 16-bit value plus control bits. The block converts the value to hex or decimal digits, with a sequential double-dabble for decimal.
- It applies enable and leading-zero blanking, then presents stable, atomically updated digit nibbles and a blank mask to the multiplexed scanner/decoder.

Parameters:
- DIG_N, 8, number of physical digits driven (2..8); digit positions >= DIG_N are always blanked.
- W, 16, width of the binary value register (fixed 16 in this release).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- ADDR  in  2  register select: 0 DATA_L, 1 DATA_H, 2 CTRL, 3 FMASK.
- DIN  in  8  write data.
- WE  in  1  write strobe, one cycle per access.
- RE  in  1  read strobe.
- DOUT  out  8  read data, registered.
- DIGITS  out  32  digit nibbles, [3:0] = digit 0 (least significant) ... [31:28] = digit 7.
- BLANK  out  8  per-digit blank, 1 = digit dark.
- BUSY  out  1  decimal conversion in progress.

Behaviour:
- Reset values:
  - DIGITS = 0, BLANK = 8'hFF, DOUT = 0, BUSY = 0.
  - DATA_L/DATA_H shadow = 0, CTRL = 0, FMASK = 0.
  - FSM enters IDLE.
- CTRL bits:
  - bit0 EN: 0 forces BLANK = FF.
  - bit1 DEC: 1 = decimal, 0 = hex.
  - bit2 LZB: leading-zero blanking.
  - bit7 BUSY: read-only; writes to it are ignored.
  - bits 6..3 read as 0.
- FMASK: force-blank mask, ORed into BLANK.
- Writes:
  - DATA_L write only loads the low shadow byte.
  - DATA_H write loads the high byte and commits {DATA_H, DATA_L} as VAL, starting an update.
  - CTRL write with a changed DEC bit also starts an update of the last committed VAL.
- Hex update: DIGITS[15:0] = VAL, DIGITS[31:16] = 0. Visible on the cycle after the commit cycle (1-cycle latency).
- Decimal update FSM:
  - IDLE -> CONV on commit; load shift register {20'b0, VAL}; BUSY = 1 from the next cycle.
  - CONV: 16 iterations, one per clk. Each iteration adds 3 to each BCD nibble >= 5, then shifts left 1.
  - CONV -> LOAD after the 16th iteration.
  - LOAD: DIGITS[19:0] = BCD result, DIGITS[31:20] = 0; BUSY = 0; return to IDLE.
  - Total: DIGITS change exactly 18 cycles after the commit cycle. 65535 -> 6,5,5,3,5 (digits 4..0).
- Atomicity: DIGITS never shows partial conversion results; the old value is held until LOAD.
- Commit during CONV: abort, reload with the new VAL, and restart the 16-iteration count. Only the newest value is ever displayed.
- Simultaneous DATA_H write and CTRL DEC change in one cycle is impossible (single port); back-to-back writes follow the restart rule.
- BLANK is registered and recomputed every cycle from the current DIGITS, CTRL and FMASK:
  - BLANK[i] = !EN | FMASK[i] | (i >= DIG_N) | (LZB & (i > msd) & (i != 0)).
  - msd = index of the highest nonzero digit; msd = 0 when the value is 0.
  - Digit 0 is never blanked by LZB.
- Reads: DOUT updates on the cycle after RE with the addressed register (CTRL includes live BUSY). With RE = 0, DOUT holds its value.
- Reset mid-CONV: conversion discarded; all outputs return to reset values the next cycle.

Decomposition:
- Shared package seg7_pkg:
  - register address constants ADDR_DATA_L/H, ADDR_CTRL, ADDR_FMASK;
  - CTRL bit indices;
  - FSM state encoding IDLE/CONV/LOAD;
  - DIG_MAX = 8.
- One sub-module: bin2bcd_seq (16-bit sequential double-dabble with start/abort/done). The controller instantiates it and owns the registers, blanking and bus interface.

Test Plan:
- Reset then idle 5 cycles -> DIGITS = 0, BLANK = FF, BUSY = 0, DOUT = 0.
- CTRL = 0x01 (hex, EN), DATA_L = 0x34, DATA_H = 0x12 -> one cycle after the DATA_H write DIGITS = 0x00001234, BLANK = 00; with LZB (CTRL = 0x05) BLANK = F0.
- CTRL = 0x07, write 0xFFFF -> BUSY = 1 for 17 cycles; DIGITS = 0x00065535 exactly 18 cycles after commit; BLANK = E0; value 0 -> BLANK = FE, DIGITS = 0.
- Decimal: commit 1234, then commit 9999 on cycle 8 of CONV -> 1234 never appears; DIGITS = 0x00009999 18 cycles after the second commit.
- DIG_N = 4, FMASK = 0x02, EN = 1, LZB = 0 -> BLANK = F2; CTRL = 0x00 -> BLANK = FF next cycle; read CTRL during CONV -> DOUT bit7 = 1.
- Assert rst on CONV cycle 10 -> DIGITS = 0, BLANK = FF, BUSY = 0 next cycle; subsequent commit converts normally.
